reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter RS_SIZE, default 16, entry count; power of two, 2..32.
REQ-002 Parameter ROB_W, default 4, ROB tag width, equal to the `ROBID field width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous reset, active-low.
REQ-006 rdy  in  1  global enable; low freezes all state.
REQ-007 DSP_sgn  in  1  dispatch valid, one instruction per cycle.
REQ-008 DSP_opcode  in  6  ALU opcode code; DSP_ROB_name  in  ROB_W  destination tag.
REQ-009 DSP_Vj, DSP_Vk  in  32 each  operand values, meaningful when the matching ready flag is 1.
REQ-010 DSP_Rj, DSP_Rk  in  1 each  operand ready flags; DSP_Qj, DSP_Qk  in  ROB_W each  producer tags when not ready.
REQ-011 CDB_sgn  in  1, CDB_result  in  32, CDB_ROB_name  in  ROB_W: ALU broadcast.
REQ-012 LSB_sgn  in  1, LSB_result  in  32, LSB_ROB_name  in  ROB_W: load broadcast (RS_LSB_FWD_EN only).
REQ-013 ROB_clear  in  1  flush on mispredict.
REQ-014 full  out  1  dispatch back-pressure.
REQ-015 ALU_sgn  out  1, ALU_opcode  out  6, ALU_ROB_name  out  ROB_W, ALU_lhs  out  32, ALU_rhs  out  32: issue port, all registered.

Function
REQ-016 Entry holds: busy, opcode, ROB tag, Vj/Rj/Qj, Vk/Rk/Qk.
REQ-017 Dispatch writes the lowest-index non-busy entry at the edge on which DSP_sgn=1.
REQ-018 Dispatch forwarding: if DSP_Rj=0 and a broadcast in the same cycle has tag DSP_Qj, the entry stores the broadcast value with Rj=1; same rule for k.
REQ-019 Wakeup: each busy entry with R=0 and Q equal to a valid broadcast tag sets V=result and R=1 at that edge.
REQ-020 Issue selects the lowest-index entry with busy=1, Rj=1 and Rk=1, judged from the registered state before the edge.
REQ-021 An entry woken at edge N is issuable at edge N+1; its values appear on the ALU port after edge N+1.
REQ-022 Issue at edge N: ALU_sgn=1 with opcode, tag, lhs=Vj, rhs=Vk valid during cycle N..N+1, and the entry is freed at edge N; otherwise ALU_sgn=0.
REQ-023 At most one issue and one dispatch per cycle; both may occur in the same cycle.
REQ-024 A freed slot is reusable by dispatch only from the following edge.
REQ-025 full = 1 when busy count >= RS_SIZE-1, computed from registered state, so that one in-flight dispatch is absorbed.
REQ-026 Dispatch with no free entry is dropped; the entry array is unchanged.
REQ-027 ROB_clear=1 at edge: all busy bits clear and ALU_sgn=0; it overrides dispatch and issue in that cycle.
REQ-028 rdy=0: no dispatch, wakeup or issue, and ALU_sgn=0; broadcasts in that cycle are lost.

Reset
REQ-029 rst low clears all busy bits immediately; ALU_sgn=0, ALU_opcode=0, ALU_ROB_name=0, ALU_lhs=0, ALU_rhs=0, full=0.
REQ-030 Reset mid-operation discards every pending entry; no issue occurs until the first edge after release plus dispatch.

Configuration
REQ-031 Macro RS_LSB_FWD_EN defined: LSB_* ports exist and are snooped identically to CDB_* in REQ-018/019; the two tags never collide in one cycle.
REQ-032 Macro RS_LSB_FWD_EN undefined: LSB_* ports are absent and only CDB_* performs wakeup and forwarding.

Verification
REQ-033 Dispatch ADD, Rj=Rk=1, Vj=5, Vk=7, tag 3 at edge 0 -> ALU_sgn=1, lhs=5, rhs=7, ALU_ROB_name=3 after edge 1.
REQ-034 Dispatch SUB with Qj=2, Rj=0 at edge 0; CDB tag 2 result 0x10 at edge 4 -> issue after edge 5 with lhs=0x10.
REQ-035 Dispatch with Qk=6 while CDB broadcasts tag 6 value 9 in the same cycle -> entry stored with rhs=9, issued the following edge.
REQ-036 Dispatch 15 never-ready entries -> full=1 after edge 15; a 16th dispatch is accepted; a 17th is dropped.
REQ-037 Entries 0 and 4 both ready -> entry 0 issues first and entry 4 issues on the next edge; ROB_clear asserted with 5 busy entries -> all freed, ALU_sgn=0, full=0.
REQ-038 RS_LSB_FWD_EN defined: LSB tag 1 value 0xAB wakes an entry waiting on Qj=1 -> lhs=0xAB at issue.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: RS_SIZE-entry ALU reservation station with dispatch forwarding and broadcast wakeup.
// Define RS_LSB_FWD_EN to add the LSB_* load broadcast as a second wakeup/forwarding source.
module reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             DSP_sgn,
  input  logic [5:0]       DSP_opcode,
  input  logic [ROB_W-1:0] DSP_ROB_name,
  input  logic [31:0]      DSP_Vj,
  input  logic [31:0]      DSP_Vk,
  input  logic             DSP_Rj,
  input  logic             DSP_Rk,
  input  logic [ROB_W-1:0] DSP_Qj,
  input  logic [ROB_W-1:0] DSP_Qk,
  input  logic             CDB_sgn,
  input  logic [31:0]      CDB_result,
  input  logic [ROB_W-1:0] CDB_ROB_name,
`ifdef RS_LSB_FWD_EN
  input  logic             LSB_sgn,
  input  logic [31:0]      LSB_result,
  input  logic [ROB_W-1:0] LSB_ROB_name,
`endif
  input  logic             ROB_clear,
  output logic             full,
  output logic             ALU_sgn,
  output logic [5:0]       ALU_opcode,
  output logic [ROB_W-1:0] ALU_ROB_name,
  output logic [31:0]      ALU_lhs,
  output logic [31:0]      ALU_rhs
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             busy;
    logic [5:0]       op;
    logic [ROB_W-1:0] rob;
    logic [31:0]      vj;
    logic             rj;
    logic [ROB_W-1:0] qj;
    logic [31:0]      vk;
    logic             rk;
    logic [ROB_W-1:0] qk;
  } rs_entry_t;

  rs_entry_t [RS_SIZE-1:0] ent, nxt;
  rs_entry_t               din;
  logic                    lsb_sgn;
  logic [31:0]             lsb_res;
  logic [ROB_W-1:0]        lsb_tag;

`ifdef RS_LSB_FWD_EN
  assign lsb_sgn = LSB_sgn;
  assign lsb_res = LSB_result;
  assign lsb_tag = LSB_ROB_name;
`else
  assign lsb_sgn = 1'b0;
  assign lsb_res = '0;
  assign lsb_tag = '0;
`endif

  // {hit, value} for a producer tag against this cycle's broadcasts
  function automatic logic [32:0] snoop(input logic [ROB_W-1:0] q, input logic cv,
                                        input logic [ROB_W-1:0] ct, input logic [31:0] cr,
                                        input logic lv, input logic [ROB_W-1:0] lt,
                                        input logic [31:0] lr);
    snoop = '0;
    if (cv && ct == q)      snoop = {1'b1, cr};
    else if (lv && lt == q) snoop = {1'b1, lr};
  endfunction

  logic             iss_hit, free_hit;
  logic [IDX_W-1:0] iss_idx, free_idx;
  logic [CNT_W-1:0] cnt;

  // descending scan so the lowest index wins
  always_comb begin
    iss_hit  = 1'b0;
    iss_idx  = '0;
    free_hit = 1'b0;
    free_idx = '0;
    cnt      = '0;
    for (int i = RS_SIZE-1; i >= 0; i--) begin
      if (ent[i].busy && ent[i].rj && ent[i].rk) begin
        iss_hit = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!ent[i].busy) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      cnt = cnt + CNT_W'(ent[i].busy);
    end
  end

  assign full = (cnt >= CNT_W'(RS_SIZE-1));

  logic [32:0] dj, dk;

  always_comb begin
    dj       = snoop(DSP_Qj, CDB_sgn, CDB_ROB_name, CDB_result, lsb_sgn, lsb_tag, lsb_res);
    dk       = snoop(DSP_Qk, CDB_sgn, CDB_ROB_name, CDB_result, lsb_sgn, lsb_tag, lsb_res);
    din      = '0;
    din.busy = 1'b1;
    din.op   = DSP_opcode;
    din.rob  = DSP_ROB_name;
    din.rj   = DSP_Rj | dj[32];
    din.vj   = DSP_Rj ? DSP_Vj : dj[31:0];
    din.qj   = DSP_Qj;
    din.rk   = DSP_Rk | dk[32];
    din.vk   = DSP_Rk ? DSP_Vk : dk[31:0];
    din.qk   = DSP_Qk;
  end

  always_comb begin
    logic [32:0] sj, sk;
    nxt = ent;
    for (int i = 0; i < RS_SIZE; i++) begin
      sj = snoop(ent[i].qj, CDB_sgn, CDB_ROB_name, CDB_result, lsb_sgn, lsb_tag, lsb_res);
      sk = snoop(ent[i].qk, CDB_sgn, CDB_ROB_name, CDB_result, lsb_sgn, lsb_tag, lsb_res);
      if (ent[i].busy && !ent[i].rj && sj[32]) begin
        nxt[i].vj = sj[31:0];
        nxt[i].rj = 1'b1;
      end
      if (ent[i].busy && !ent[i].rk && sk[32]) begin
        nxt[i].vk = sk[31:0];
        nxt[i].rk = 1'b1;
      end
    end
    if (iss_hit) nxt[iss_idx].busy = 1'b0;
    // free slot comes from registered state, so a slot issued this edge is not reused yet
    if (DSP_sgn && free_hit) nxt[free_idx] = din;
    if (ROB_clear)
      for (int i = 0; i < RS_SIZE; i++) nxt[i].busy = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ent <= '0;
    else if (rdy) ent <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALU_sgn      <= 1'b0;
      ALU_opcode   <= '0;
      ALU_ROB_name <= '0;
      ALU_lhs      <= '0;
      ALU_rhs      <= '0;
    end else if (!rdy || ROB_clear) begin
      ALU_sgn <= 1'b0;
    end else begin
      ALU_sgn <= iss_hit;
      if (iss_hit) begin
        ALU_opcode   <= ent[iss_idx].op;
        ALU_ROB_name <= ent[iss_idx].rob;
        ALU_lhs      <= ent[iss_idx].vj;
        ALU_rhs      <= ent[iss_idx].vk;
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus randomized traffic against a behavioural model.
module tb_reservation_station;
  localparam int N = 16;

  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b0;
  logic        DSP_sgn = 1'b0, DSP_Rj = 1'b0, DSP_Rk = 1'b0;
  logic [5:0]  DSP_opcode = '0;
  logic [3:0]  DSP_ROB_name = '0, DSP_Qj = '0, DSP_Qk = '0;
  logic [31:0] DSP_Vj = '0, DSP_Vk = '0;
  logic        CDB_sgn = 1'b0;
  logic [31:0] CDB_result = '0;
  logic [3:0]  CDB_ROB_name = '0;
`ifdef RS_LSB_FWD_EN
  logic        LSB_sgn = 1'b0;
  logic [31:0] LSB_result = '0;
  logic [3:0]  LSB_ROB_name = '0;
`endif
  logic        ROB_clear = 1'b0;
  logic        full, ALU_sgn;
  logic [5:0]  ALU_opcode;
  logic [3:0]  ALU_ROB_name;
  logic [31:0] ALU_lhs, ALU_rhs;

  reservation_station #(.RS_SIZE(N), .ROB_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .DSP_sgn(DSP_sgn), .DSP_opcode(DSP_opcode), .DSP_ROB_name(DSP_ROB_name),
    .DSP_Vj(DSP_Vj), .DSP_Vk(DSP_Vk), .DSP_Rj(DSP_Rj), .DSP_Rk(DSP_Rk),
    .DSP_Qj(DSP_Qj), .DSP_Qk(DSP_Qk),
    .CDB_sgn(CDB_sgn), .CDB_result(CDB_result), .CDB_ROB_name(CDB_ROB_name),
`ifdef RS_LSB_FWD_EN
    .LSB_sgn(LSB_sgn), .LSB_result(LSB_result), .LSB_ROB_name(LSB_ROB_name),
`endif
    .ROB_clear(ROB_clear), .full(full),
    .ALU_sgn(ALU_sgn), .ALU_opcode(ALU_opcode), .ALU_ROB_name(ALU_ROB_name),
    .ALU_lhs(ALU_lhs), .ALU_rhs(ALU_rhs)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // behavioural model: a table of pending instructions plus the last issue
  logic        m_busy[N], m_rj[N], m_rk[N];
  logic [5:0]  m_op[N];
  logic [3:0]  m_tag[N], m_qj[N], m_qk[N];
  logic [31:0] m_vj[N], m_vk[N];
  logic        m_sgn;
  logic [5:0]  m_aop;
  logic [3:0]  m_arob;
  logic [31:0] m_lhs, m_rhs;

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
    m_sgn = 1'b0; m_aop = '0; m_arob = '0; m_lhs = '0; m_rhs = '0;
  endtask

  task automatic m_snoop(input logic [3:0] q, output logic h, output logic [31:0] v);
    h = 1'b0; v = '0;
    if (CDB_sgn && CDB_ROB_name == q) begin h = 1'b1; v = CDB_result; end
`ifdef RS_LSB_FWD_EN
    else if (LSB_sgn && LSB_ROB_name == q) begin h = 1'b1; v = LSB_result; end
`endif
  endtask

  task automatic model_step();
    int iss, fr;
    logic h;
    logic [31:0] v;
    iss = -1; fr = -1;
    if (!rdy) m_sgn = 1'b0;
    else if (ROB_clear) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_sgn = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (iss < 0 && m_busy[i] && m_rj[i] && m_rk[i]) iss = i;
        if (fr < 0 && !m_busy[i]) fr = i;
      end
      for (int i = 0; i < N; i++) if (m_busy[i]) begin
        if (!m_rj[i]) begin m_snoop(m_qj[i], h, v); if (h) begin m_rj[i] = 1'b1; m_vj[i] = v; end end
        if (!m_rk[i]) begin m_snoop(m_qk[i], h, v); if (h) begin m_rk[i] = 1'b1; m_vk[i] = v; end end
      end
      m_sgn = (iss >= 0);
      if (iss >= 0) begin
        m_aop = m_op[iss]; m_arob = m_tag[iss]; m_lhs = m_vj[iss]; m_rhs = m_vk[iss];
        m_busy[iss] = 1'b0;
      end
      if (DSP_sgn && fr >= 0) begin
        m_busy[fr] = 1'b1; m_op[fr] = DSP_opcode; m_tag[fr] = DSP_ROB_name;
        m_qj[fr] = DSP_Qj; m_qk[fr] = DSP_Qk;
        m_rj[fr] = DSP_Rj; m_vj[fr] = DSP_Vj;
        m_rk[fr] = DSP_Rk; m_vk[fr] = DSP_Vk;
        if (!DSP_Rj) begin m_snoop(DSP_Qj, h, v); if (h) begin m_rj[fr] = 1'b1; m_vj[fr] = v; end end
        if (!DSP_Rk) begin m_snoop(DSP_Qk, h, v); if (h) begin m_rk[fr] = 1'b1; m_vk[fr] = v; end end
      end
    end
  endtask

  task automatic check_out();
    int c;
    c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    chk("alu_sgn", 32'(ALU_sgn), 32'(m_sgn));
    chk("alu_op", 32'(ALU_opcode), 32'(m_aop));
    chk("alu_rob", 32'(ALU_ROB_name), 32'(m_arob));
    chk("alu_lhs", ALU_lhs, m_lhs);
    chk("alu_rhs", ALU_rhs, m_rhs);
    chk("full", 32'(full), 32'(c >= N-1));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic idle();
    rdy = 1'b1; DSP_sgn = 1'b0; CDB_sgn = 1'b0; ROB_clear = 1'b0;
`ifdef RS_LSB_FWD_EN
    LSB_sgn = 1'b0;
`endif
  endtask

  task automatic dsp(input logic [5:0] op, input logic [3:0] tag,
                     input logic rj, input logic [31:0] vj, input logic [3:0] qj,
                     input logic rk, input logic [31:0] vk, input logic [3:0] qk);
    DSP_sgn = 1'b1; DSP_opcode = op; DSP_ROB_name = tag;
    DSP_Rj = rj; DSP_Vj = vj; DSP_Qj = qj;
    DSP_Rk = rk; DSP_Vk = vk; DSP_Qk = qk;
  endtask

  initial begin
    m_reset();
    #2;
    chk("rst_sgn", 32'(ALU_sgn), 0);
    chk("rst_op", 32'(ALU_opcode), 0);
    chk("rst_rob", 32'(ALU_ROB_name), 0);
    chk("rst_lhs", ALU_lhs, 0);
    chk("rst_rhs", ALU_rhs, 0);
    chk("rst_full", 32'(full), 0);
    rst = 1'b1;
    idle();

    // ready ADD issues one edge after dispatch
    dsp(6'd1, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    tick(); idle(); tick();
    chk("add_sgn", 32'(ALU_sgn), 1);
    chk("add_lhs", ALU_lhs, 5);
    chk("add_rhs", ALU_rhs, 7);
    chk("add_rob", 32'(ALU_ROB_name), 3);
    tick();

    // SUB waiting on tag 2, woken at edge 4, issued at edge 5
    dsp(6'd2, 4'd1, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0);
    tick(); idle(); tick(); tick(); tick();
    CDB_sgn = 1'b1; CDB_ROB_name = 4'd2; CDB_result = 32'h10;
    tick(); idle();
    chk("wake_early", 32'(ALU_sgn), 0);
    tick();
    chk("wake_sgn", 32'(ALU_sgn), 1);
    chk("wake_lhs", ALU_lhs, 32'h10);

    // same-cycle forwarding into the k operand
    dsp(6'd3, 4'd5, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6);
    CDB_sgn = 1'b1; CDB_ROB_name = 4'd6; CDB_result = 32'd9;
    tick(); idle(); tick();
    chk("fwd_sgn", 32'(ALU_sgn), 1);
    chk("fwd_rhs", ALU_rhs, 9);
    tick();

    // fill: full at 15 entries, 16th accepted, 17th dropped
    for (int i = 0; i < 15; i++) begin
      dsp(6'd4, 4'(i), 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
      tick();
    end
    chk("full_15", 32'(full), 1);
    dsp(6'd4, 4'd15, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
    tick();
    chk("full_16", 32'(full), 1);
    dsp(6'd5, 4'd7, 1'b1, 32'h77, 4'd0, 1'b1, 32'h88, 4'd0);
    tick(); idle(); tick();
    chk("drop_17", 32'(ALU_sgn), 0);
    ROB_clear = 1'b1;
    tick(); idle();
    chk("clr_full", 32'(full), 0);

    // entries 0 and 4 woken together issue in index order
    for (int i = 0; i < 5; i++) begin
      dsp(6'd6, 4'(10 + i), 1'b0, 32'd0, (i == 0 || i == 4) ? 4'd9 : 4'd15, 1'b1, 32'd2, 4'd0);
      tick();
    end
    idle();
    CDB_sgn = 1'b1; CDB_ROB_name = 4'd9; CDB_result = 32'h55;
    tick(); idle(); tick();
    chk("ord_first", 32'(ALU_ROB_name), 10);
    tick();
    chk("ord_second", 32'(ALU_ROB_name), 14);
    chk("ord_lhs", ALU_lhs, 32'h55);
    for (int i = 0; i < 2; i++) begin
      dsp(6'd7, 4'd8, 1'b0, 32'd0, 4'd15, 1'b1, 32'd0, 4'd0);
      tick();
    end
    idle(); ROB_clear = 1'b1;
    tick(); idle();
    chk("clr5_sgn", 32'(ALU_sgn), 0);
    chk("clr5_full", 32'(full), 0);

`ifdef RS_LSB_FWD_EN
    dsp(6'd8, 4'd2, 1'b0, 32'd0, 4'd1, 1'b1, 32'd3, 4'd0);
    tick(); idle();
    LSB_sgn = 1'b1; LSB_ROB_name = 4'd1; LSB_result = 32'hAB;
    tick(); idle(); tick();
    chk("lsb_lhs", ALU_lhs, 32'hAB);
`endif

    // asynchronous reset mid-operation drops pending ready work
    dsp(6'd9, 4'd4, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
    tick(); idle();
    dsp(6'd9, 4'd5, 1'b1, 32'd2, 4'd0, 1'b1, 32'd2, 4'd0);
    tick(); idle();
    rst = 1'b0;
    #1;
    chk("mid_rst_sgn", 32'(ALU_sgn), 0);
    chk("mid_rst_full", 32'(full), 0);
    m_reset();
    #1 rst = 1'b1;
    tick();
    chk("post_rst_idle", 32'(ALU_sgn), 0);

    // randomized traffic, including stalls and flushes
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      ROB_clear = ($urandom_range(0, 39) == 0);
      DSP_sgn = ($urandom_range(0, 2) != 0);
      DSP_opcode = 6'($urandom); DSP_ROB_name = 4'($urandom);
      DSP_Rj = 1'($urandom); DSP_Vj = $urandom; DSP_Qj = 4'($urandom);
      DSP_Rk = 1'($urandom); DSP_Vk = $urandom; DSP_Qk = 4'($urandom);
      CDB_sgn = 1'($urandom); CDB_ROB_name = 4'($urandom); CDB_result = $urandom;
`ifdef RS_LSB_FWD_EN
      LSB_sgn = 1'($urandom); LSB_ROB_name = 4'($urandom); LSB_result = $urandom;
      if (CDB_sgn && LSB_ROB_name == CDB_ROB_name) LSB_sgn = 1'b0;
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
